am_insertion_tx: RTL and testbench
==================================

// Module: am_insertion_tx
// PURPOSE
//  TX-side counterpart of the RX lane deskew: inserts one 802.3ba alignment marker (AM) per PCS lane
//  every AM_PERIOD data words, so the far end can lock, measure and remove inter-lane skew.
//  Sits after block distribution, before the lane muxes. Word = N_LANES parallel 66b blocks, lane 0 in the MSB slot.
//  Keeps a per-lane BIP8 accumulator and stalls upstream for the AM cycle.
// PARAMETERS
//  N_LANES      20                   PCS lanes per word
//  NB_DATA      66                   bits per lane block
//  AM_PERIOD    16383                data words between consecutive AM words (>=2)
//  NB_PERIOD    $clog2(AM_PERIOD+1)  period counter width
//  NB_DATA_BUS  NB_DATA*N_LANES      bus width
// PORTS
//  i_clock      in   1            clock
//  i_reset      in   1            asynchronous, active-low reset
//  i_enable     in   1            block enable; low = flush to IDLE
//  i_valid      in   1            upstream word valid; accepted only when i_valid & o_ready
//  i_data       in   NB_DATA_BUS  lane blocks; lane i at [NB_DATA_BUS-1-i*NB_DATA -: NB_DATA]
//  o_ready      out  1            upstream may present/advance a word this cycle
//  o_valid      out  1            o_data valid
//  o_data       out  NB_DATA_BUS  lane blocks or AM blocks, same lane mapping
//  o_am_insert  out  1            o_data is an AM word (all lanes)
// BEHAVIOUR
//  Reset (i_reset=0): state=IDLE, period count=0, all BIP accumulators=0, o_ready=0, o_valid=0,
//   o_am_insert=0, o_data=0. Every output is registered; latency is 1 cycle from accept to o_data.
//  FSM:
//   IDLE: o_ready=0. On i_enable=1 -> INSERT_AM.
//   INSERT_AM: emits one AM word (o_valid=1, o_am_insert=1), o_ready=0, count<=0 -> PASS_DATA.
//   PASS_DATA: o_ready=1. Accept -> o_data<=i_data, o_valid=1, count++. When count reaches AM_PERIOD
//    with the accept in that cycle -> INSERT_AM. No accept -> o_valid=0, o_data held, count unchanged.
//   i_enable=0 in any state -> IDLE next cycle; count, accumulators, o_valid and o_am_insert cleared.
//   The first word after enable is always an AM.
//  Handshake: o_ready is a registered state decode; a word presented while o_ready=0 is not consumed
//   and must be held by upstream. o_ready falls in the cycle the AM is emitted (exactly 1 cycle per period).
//  AM block per lane L: {2'b10, M0[L],M1[L],M2[L],BIP3[L],M4[L],M5[L],M6[L],BIP7[L]}, BIP7 = ~BIP3.
//   Bit numbering for BIP: tx bit k = block[65-k] (bit 0 = sync header MSB).
//  BIP3 bit j = XOR over covered blocks of tx bits {j+2, j+10, ..., j+58} for j=0..2;
//   bits 3/4 also include tx bit 0/1; bits 5..7 use {j+2, ..., j+58}, i.e. tx bits 7..65 step 8.
//  Coverage: all blocks from and including the previous AM up to, not including, the current AM.
//   On emitting an AM the accumulator is loaded with the parity of that AM block itself
//   (the sum is taken with the accumulator value just before the load).
//   The first AM after enable carries BIP3=8'h00.
//  Count wrap: the counter never exceeds AM_PERIOD; it is cleared on every AM.
//  Simultaneous i_enable fall and accept: enable wins; the word is not accepted.
// STRUCTURE
//  Package am_tx_pkg: per-lane marker table AM_M0/M1/M2[0:19] (lane0 C1/68/21, lane1 9D/71/8E, ...)
//   with M4..M6 = ~M0..M2; FSM state encodings; AM sync header constant 2'b10.
//  Sub-module bip8_lane: one per lane (generate), computes 8-bit parity of a 66b block
//   combinationally and holds the registered accumulator with clear/load/accumulate controls.
// TESTING (AM_PERIOD=4, N_LANES=20)
//  Reset then i_enable=1, i_valid=1 held -> cycle1 AM word (o_am_insert=1, lane0 =
//   {2'b10,C1,68,21,00,3E,97,DE,FF}), then 4 data words, then AM again; o_ready low exactly on AM cycles.
//  All-zero data over a period -> next AM BIP3 equals the parity of the previous AM block only.
//   A single 1 at tx bit 10 of lane 3 -> lane3 BIP3 bit0 toggles; other lanes unchanged.
//  i_valid gaps (valid 1,0,0,1,1,1) -> exactly 4 accepted words between AMs; o_valid=0 on gap cycles.
//  i_enable dropped mid-period (count=2) then raised -> IDLE 1 cycle, fresh AM with BIP3=00, count restarts.
//  i_reset asserted mid-AM cycle -> all outputs 0 asynchronously; after release the first
//   word after enable is an AM.

Source files
------------

// File: rtl/am_tx_pkg.sv
// rtl/am_tx_pkg.sv - alignment marker tables, FSM states and AM constants
package am_tx_pkg;

  localparam int         AM_LANES = 20;
  localparam logic [1:0] AM_SYNC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INSERT_AM = 2'd1,
    ST_PASS_DATA = 2'd2
  } am_state_e;

  // {M0, M1, M2} per PCS lane; M4..M6 are the bitwise complements
  function automatic logic [23:0] am_marker(input int lane);
    logic [23:0] m;
    case (lane)
      0:       m = 24'hC16821;
      1:       m = 24'h9D718E;
      2:       m = 24'h594BE8;
      3:       m = 24'h4D957B;
      4:       m = 24'hF50709;
      5:       m = 24'hDD14C2;
      6:       m = 24'h9A4A26;
      7:       m = 24'h7B4566;
      8:       m = 24'hA02476;
      9:       m = 24'h68C9FB;
      10:      m = 24'hFD6C99;
      11:      m = 24'hB99155;
      12:      m = 24'h5CB9B2;
      13:      m = 24'h1AF8BD;
      14:      m = 24'h83C7CA;
      15:      m = 24'h3536CD;
      16:      m = 24'hC4314C;
      17:      m = 24'hADD6B7;
      18:      m = 24'h5F662A;
      default: m = 24'hC0F0E5;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bip8_lane.sv
// rtl/bip8_lane.sv - per-lane BIP8 parity of a 66b block plus running accumulator
module bip8_lane
  import am_tx_pkg::*;
#(
  parameter int NB_DATA = 66
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_block,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_accum,
  output logic [7:0]         o_parity,
  output logic [7:0]         o_acc
);

  // tx bit k is i_block[NB_DATA-1-k]; payload bits fold mod 8, sync header bits land in 3 and 4
  always_comb begin
    o_parity = '0;
    for (int k = 2; k < NB_DATA; k++) begin
      o_parity[3'((k - 2) % 8)] = o_parity[3'((k - 2) % 8)] ^ i_block[NB_DATA-1-k];
    end
    o_parity[3] = o_parity[3] ^ i_block[NB_DATA-1];
    o_parity[4] = o_parity[4] ^ i_block[NB_DATA-2];
  end

  // Accumulator: clear wins, then load (AM cycle), then accumulate (accepted data)
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_acc <= '0;
    end else if (i_clear) begin
      o_acc <= '0;
    end else if (i_load) begin
      o_acc <= o_parity;
    end else if (i_accum) begin
      o_acc <= o_acc ^ o_parity;
    end
  end

endmodule

// File: rtl/am_insertion_tx.sv
// rtl/am_insertion_tx.sv - inserts one alignment marker per lane every AM_PERIOD words
module am_insertion_tx
  import am_tx_pkg::*;
#(
  parameter int N_LANES     = 20,
  parameter int NB_DATA     = 66,
  parameter int AM_PERIOD   = 16383,
  parameter int NB_PERIOD   = $clog2(AM_PERIOD + 1),
  parameter int NB_DATA_BUS = NB_DATA * N_LANES
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic [NB_DATA_BUS-1:0] i_data,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [NB_DATA_BUS-1:0] o_data,
  output logic                   o_am_insert
);

  am_state_e              state, state_next;
  logic [NB_PERIOD-1:0]   count;
  logic [NB_DATA_BUS-1:0] am_word;
  logic                   accept;
  logic                   count_done;

  // Enable low blocks the transfer even if ready and valid coincide
  assign accept     = i_enable && i_valid && o_ready;
  assign count_done = (count == NB_PERIOD'(AM_PERIOD - 1));

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic [23:0]        marker;
    logic [7:0]         acc;
    logic [7:0]         parity;
    logic [NB_DATA-1:0] blk;

    assign marker = am_marker(l % AM_LANES);
    assign am_word[NB_DATA_BUS-1-l*NB_DATA -: NB_DATA] = {AM_SYNC, marker, acc, ~marker, ~acc};
    // The AM block's own parity seeds the next period, so feed it in on the AM cycle
    assign blk = (state == ST_INSERT_AM) ? am_word[NB_DATA_BUS-1-l*NB_DATA -: NB_DATA]
                                         : i_data[NB_DATA_BUS-1-l*NB_DATA -: NB_DATA];

    bip8_lane #(.NB_DATA(NB_DATA)) u_bip (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_block  (blk),
      .i_clear  (!i_enable || (state == ST_IDLE)),
      .i_load   (i_enable && (state == ST_INSERT_AM)),
      .i_accum  (accept),
      .o_parity (parity),
      .o_acc    (acc)
    );
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enable low always flushes to IDLE; the period ends on the AM_PERIOD-th accept
  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_next = ST_INSERT_AM;
        ST_INSERT_AM: state_next = ST_PASS_DATA;
        ST_PASS_DATA: if (accept && count_done) state_next = ST_INSERT_AM;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Ready is a registered decode of the upcoming state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready <= 1'b0;
    end else begin
      o_ready <= (state_next == ST_PASS_DATA);
    end
  end

  // Output word and period counter: AM leaves INSERT_AM, accepted data passes through
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid     <= 1'b0;
      o_am_insert <= 1'b0;
      o_data      <= '0;
      count       <= '0;
    end else if (!i_enable) begin
      o_valid     <= 1'b0;
      o_am_insert <= 1'b0;
      count       <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_am_insert <= 1'b0;
      case (state)
        ST_INSERT_AM: begin
          o_valid     <= 1'b1;
          o_am_insert <= 1'b1;
          o_data      <= am_word;
          count       <= '0;
        end
        ST_PASS_DATA: begin
          if (accept) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            count   <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_am_insertion_tx.sv
// tb/tb_am_insertion_tx.sv - scoreboard bench for am_insertion_tx
module tb_am_insertion_tx;

  localparam int NL  = 20;
  localparam int NB  = 66;
  localparam int PER = 4;
  localparam int BUS = NL * NB;

  typedef struct packed {
    logic           am;
    logic [BUS-1:0] data;
  } exp_t;

  logic           i_clock = 1'b0;
  logic           i_reset;
  logic           i_enable;
  logic           i_valid;
  logic [BUS-1:0] i_data;
  logic           o_ready;
  logic           o_valid;
  logic [BUS-1:0] o_data;
  logic           o_am_insert;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [23:0] mk [0:NL-1];
  logic [7:0]  cov [0:NL-1];
  int          model_words = 0;
  int          dmode = 0;
  int          rdy_low = 0;
  int          am_seen = 0;
  logic        prev_ready = 1'b0;

  always #5 i_clock = ~i_clock;

  am_insertion_tx #(.N_LANES(NL), .NB_DATA(NB), .AM_PERIOD(PER)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_am_insert (o_am_insert)
  );

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // BIP8 of one block: tx bit k (= b[65-k]) goes to bit (k-2) mod 8, tx bits 0/1 to bits 3/4
  function automatic logic [7:0] bip_of(input logic [NB-1:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) begin
      int j;
      j = (k < 2) ? k + 3 : (k - 2) % 8;
      p[j] = p[j] ^ b[NB-1-k];
    end
    return p;
  endfunction

  function automatic logic [NB-1:0] lane_of(input logic [BUS-1:0] w, input int l);
    return w[BUS-1-l*NB -: NB];
  endfunction

  // Reference: stream is AM, PER data words, AM, ...; each AM carries parity of everything since the last AM
  task automatic push_am();
    exp_t e;
    e.am   = 1'b1;
    e.data = '0;
    for (int l = 0; l < NL; l++) e.data[BUS-1-l*NB -: NB] = {2'b10, mk[l], cov[l], ~mk[l], ~cov[l]};
    for (int l = 0; l < NL; l++) cov[l] = bip_of(lane_of(e.data, l));
    q.push_back(e);
    model_words = 0;
  endtask

  task automatic model_start();
    for (int l = 0; l < NL; l++) cov[l] = 8'h00;
    push_am();
  endtask

  task automatic model_accept(input logic [BUS-1:0] d);
    exp_t e;
    e.am   = 1'b0;
    e.data = d;
    q.push_back(e);
    for (int l = 0; l < NL; l++) cov[l] = cov[l] ^ bip_of(lane_of(d, l));
    model_words++;
    if (model_words == PER) push_am();
  endtask

  function automatic logic [BUS-1:0] gen_word();
    logic [BUS-1:0] w;
    w = '0;
    if (dmode == 0) begin
      for (int i = 0; i < BUS; i++) w[i] = 1'($urandom_range(0, 1));
    end else if (dmode == 2 && model_words == 0) begin
      w[BUS-1-3*NB-10] = 1'b1;
    end
    return w;
  endfunction

  // One cycle of upstream: transfer decided before the edge; data/valid held until consumed
  task automatic step(input bit nv);
    bit acc;
    @(negedge i_clock);
    acc = i_enable && i_valid && o_ready;
    @(posedge i_clock);
    #1;
    if (acc) model_accept(i_data);
    if (acc || !i_valid) begin
      i_valid = nv;
      i_data  = gen_word();
    end
  endtask

  // Monitor: pop expected word whenever the DUT presents one
  always @(negedge i_clock) begin
    if (i_reset) begin
      if (!o_ready) rdy_low++;
      if (o_valid) begin
        if (o_am_insert) begin
          am_seen++;
          chk("am_ready_low_before", NB'(prev_ready), NB'(0));
        end
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got_am=%0b", o_am_insert);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_am_flag", NB'(o_am_insert), NB'(e.am));
          total++;
          if (o_data !== e.data) begin
            bad++;
            for (int l = 0; l < NL; l++) begin
              if (lane_of(o_data, l) !== lane_of(e.data, l)) begin
                $display("FAIL sb_data lane=%0d got=%h exp=%h", l, lane_of(o_data, l), lane_of(e.data, l));
                break;
              end
            end
          end
        end
      end else if (o_am_insert) begin
        total++;
        bad++;
        $display("FAIL am_without_valid got=1 exp=0");
      end
    end
    prev_ready = o_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int rl0, am0;
    bit found;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mk = '{24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
           24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
           24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
           24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("reset_o_ready", NB'(o_ready), NB'(0));
    chk("reset_o_valid", NB'(o_valid), NB'(0));
    chk("reset_o_am_insert", NB'(o_am_insert), NB'(0));
    chk("reset_o_data_nonzero", NB'(|o_data), NB'(0));
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;

    // First AM after enable, lane 0 against the literal marker block
    i_enable = 1'b1;
    model_start();
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge i_clock);
      if (o_am_insert) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL first_am_seen got=0 exp=1");
    end
    chk("first_am_lane0", lane_of(o_data, 0), 66'h2C16821003E97DEFF);

    // Steady stream with valid held: one ready-low cycle and one AM per PER+1 cycles
    dmode = 0;
    repeat (12) step(1'b1);
    rl0 = rdy_low;
    am0 = am_seen;
    repeat (5 * (PER + 1)) step(1'b1);
    chk("ready_low_per_window", NB'(rdy_low - rl0), NB'(5));
    chk("am_per_window", NB'(am_seen - am0), NB'(5));

    // All-zero periods, then a single tx bit 10 in lane 3 at the start of each period
    dmode = 1;
    repeat (3 * (PER + 1)) step(1'b1);
    dmode = 2;
    repeat (3 * (PER + 1)) step(1'b1);

    // Valid gaps: fixed pattern, then random
    dmode = 0;
    for (int r = 0; r < 3; r++) foreach (pat[i]) step(pat[i]);
    repeat (40) step(1'($urandom_range(0, 1)));

    // Enable dropped with two words into the period, raised again after one cycle
    for (int t = 0; t < 30 && model_words != 2; t++) step(1'b1);
    total++;
    if (model_words != 2) begin
      bad++;
      $display("FAIL enable_drop_setup got=%0d exp=2", model_words);
    end
    i_enable = 1'b0;
    step(1'b1);
    i_enable = 1'b1;
    model_start();
    repeat (15) step(1'b1);

    // Asynchronous reset while an AM word is on the output
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      step(1'b1);
      if (o_am_insert) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_am_setup got=0 exp=1");
    end
    #2;
    i_reset = 1'b0;
    #1;
    chk("async_reset_o_ready", NB'(o_ready), NB'(0));
    chk("async_reset_o_valid", NB'(o_valid), NB'(0));
    chk("async_reset_o_am_insert", NB'(o_am_insert), NB'(0));
    chk("async_reset_o_data_nonzero", NB'(|o_data), NB'(0));
    q.delete();
    @(posedge i_clock);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    model_start();
    repeat (15) step(1'b1);
    repeat (20) step(1'($urandom_range(0, 1)));

    // Drain and confirm every expected word was presented
    repeat (10) step(1'b0);
    chk("sb_leftover", NB'(q.size()), NB'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
